vga_plot_arbiter: RTL and testbench

- Shares the single pixel write port of vga_adapter (x, y, colour, plot) among NREQ drawing engines, e.g. background restore, sprite/circle drawer and cursor.
- Arbitration is round-robin with burst locking, so one engine's object is never interleaved with another's. A burst cap keeps the other engines from starving.
- Clips out-of-screen pixels and drives the adapter port through registered outputs.
- Sits between the part2-style datapaths and vga_adapter in top.

---
 rtl/vga_plot_arbiter.sv | 150 +++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin, burst-locked arbiter that shares the vga_adapter pixel port
// among NREQ drawing engines, clipping off-screen pixels before the write.
module vga_plot_arbiter #(
  parameter int NREQ     = 3,
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int CW       = 15,
  parameter int XMAX     = 319,
  parameter int YMAX     = 239,
  parameter int MAXBURST = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    last,
  input  logic [NREQ*XW-1:0] px,
  input  logic [NREQ*YW-1:0] py,
  input  logic [NREQ*CW-1:0] pcol,
  output logic [NREQ-1:0]    ack,
  output logic [XW-1:0]      vga_x,
  output logic [YW-1:0]      vga_y,
  output logic [CW-1:0]      vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic [2:0]         owner,
  output logic [15:0]        clip_count
);

  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] CAP_M1 = BW'(MAXBURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      last_owner_q;
  logic [BW-1:0]   burst_cnt_q;
  logic [2:0]      win;
  logic            win_found;
  logic            own_req, own_last;
  logic [XW-1:0]   sel_x;
  logic [YW-1:0]   sel_y;
  logic [CW-1:0]   sel_col;
  logic            clipped;
  logic            accept;
  logic            release_now;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Rotating priority: first look above last_owner, then wrap to the bottom.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i] && (i[2:0] > last_owner_q)) begin
        win       = i[2:0];
        win_found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i]) begin
        win       = i[2:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_col  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == i[2:0]) begin
        own_req  = req[i];
        own_last = last[i];
        sel_x    = px[i*XW +: XW];
        sel_y    = py[i*YW +: YW];
        sel_col  = pcol[i*CW +: CW];
      end
    end
  end

  assign clipped = (int'(sel_x) > XMAX) || (int'(sel_y) > YMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ack         = '0;
    accept      = 1'b0;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) state_d = OWN;
      end
      OWN: begin
        for (int i = 0; i < NREQ; i++) begin
          if (owner == i[2:0]) ack[i] = req[i];
        end
        accept = own_req;
        // Dropping req, last pixel and burst cap all end the grant the same way.
        if (!own_req || own_last || (burst_cnt_q == CAP_M1)) begin
          state_d     = IDLE;
          release_now = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == OWN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner        <= '0;
      last_owner_q <= 3'(NREQ - 1);
      burst_cnt_q  <= '0;
      vga_plot     <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      clip_count   <= '0;
    end else begin
      vga_plot <= 1'b0;
      if (state_q == IDLE && win_found) begin
        owner       <= win;
        burst_cnt_q <= '0;
      end
      if (accept) begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
        if (clipped) begin
          clip_count <= sat_inc16(clip_count);
        end else begin
          vga_plot   <= 1'b1;
          vga_x      <= sel_x;
          vga_y      <= sel_y;
          vga_colour <= sel_col;
        end
      end
      if (release_now) last_owner_q <= owner;
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a behavioural model of the arbiter.
module tb_vga_plot_arbiter;

  localparam int NREQ = 3;
  localparam int XW   = 9;
  localparam int YW   = 8;
  localparam int CW   = 15;
  localparam int MB   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    last = '0;
  logic [NREQ*XW-1:0] px = '0;
  logic [NREQ*YW-1:0] py = '0;
  logic [NREQ*CW-1:0] pcol = '0;
  logic [NREQ-1:0]    ack;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_colour;
  logic               vga_plot;
  logic               busy;
  logic [2:0]         owner;
  logic [15:0]        clip_count;

  always #5 clk = ~clk;

  vga_plot_arbiter #(
    .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW),
    .XMAX(319), .YMAX(239), .MAXBURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .last(last),
    .px(px), .py(py), .pcol(pcol), .ack(ack),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .owner(owner), .clip_count(clip_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: granted engine (or none), pixels taken this grant,
  // who was served last, and the write the adapter should see.
  bit  m_granted;
  int  m_owner, m_last, m_taken, m_clip;
  bit  m_plot;
  int  m_x, m_y, m_col;
  logic [NREQ-1:0] obs_ack;

  task automatic model_reset();
    m_granted = 0; m_owner = 0; m_last = NREQ - 1; m_taken = 0;
    m_clip = 0; m_plot = 0; m_x = 0; m_y = 0; m_col = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                            input logic [NREQ*XW-1:0] x, input logic [NREQ*YW-1:0] y,
                            input logic [NREQ*CW-1:0] c);
    int xx, yy, cc;
    bit found;
    m_plot = 0;
    if (!m_granted) begin
      if (r != 0) begin
        found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_last + k) % NREQ;
          if (!found && r[i]) begin
            m_owner = i;
            found = 1;
          end
        end
        m_granted = 1;
        m_taken = 0;
      end
    end else if (r[m_owner]) begin
      xx = int'(x[m_owner*XW +: XW]);
      yy = int'(y[m_owner*YW +: YW]);
      cc = int'(c[m_owner*CW +: CW]);
      if (xx <= 319 && yy <= 239) begin
        m_plot = 1; m_x = xx; m_y = yy; m_col = cc;
      end else if (m_clip < 65535) begin
        m_clip++;
      end
      m_taken++;
      if (l[m_owner] || m_taken == MB) begin
        m_last = m_owner;
        m_granted = 0;
      end
    end else begin
      m_last = m_owner;
      m_granted = 0;
    end
  endtask

  // One clock: inputs applied after a falling edge, ack checked, model stepped
  // on the rising edge, registered outputs checked on the next falling edge.
  task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                     input logic [NREQ*XW-1:0] x, input logic [NREQ*YW-1:0] y,
                     input logic [NREQ*CW-1:0] c);
    logic [NREQ-1:0] ea;
    req = r; last = l; px = x; py = y; pcol = c;
    #1;
    ea = '0;
    if (m_granted && r[m_owner]) ea[m_owner] = 1'b1;
    obs_ack = ack;
    check("ack", ack, ea);
    @(posedge clk);
    model_step(r, l, x, y, c);
    @(negedge clk);
    check("vga_plot", vga_plot, m_plot);
    check("vga_x", vga_x, m_x);
    check("vga_y", vga_y, m_y);
    check("vga_colour", vga_colour, m_col);
    check("busy", busy, m_granted);
    check("clip_count", clip_count, m_clip);
    if (m_granted) check("owner", owner, m_owner);
  endtask

  task automatic cyc_s(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input int x, input int y, input int c);
    cyc(r, l, {NREQ{XW'(x)}}, {NREQ{YW'(y)}}, {NREQ{CW'(c)}});
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; last = '0;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_ack", ack, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip_count, 0);
    check("rst_x", vga_x, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int rand_x();
    case ($urandom_range(0, 3))
      0: return 319;
      1: return 320 + $urandom_range(0, 191);
      default: return $urandom_range(0, 319);
    endcase
  endfunction

  function automatic int rand_y();
    case ($urandom_range(0, 3))
      0: return 239;
      1: return 240 + $urandom_range(0, 15);
      default: return $urandom_range(0, 239);
    endcase
  endfunction

  initial begin
    int order[$];
    bit prev_busy;
    int n1;
    bit seen2;
    logic [NREQ-1:0] r, l;
    logic [NREQ*XW-1:0] x;
    logic [NREQ*YW-1:0] y;
    logic [NREQ*CW-1:0] c;

    model_reset();

    // Single requester, three-pixel burst.
    do_reset();
    cyc_s(3'b001, 3'b000, 10, 20, 'h7fff);
    cyc_s(3'b001, 3'b000, 10, 20, 'h7fff);
    cyc_s(3'b001, 3'b000, 11, 20, 'h7fff);
    cyc_s(3'b001, 3'b001, 12, 20, 'h001f);
    cyc_s(3'b000, 3'b000, 0, 0, 0);
    cyc_s(3'b000, 3'b000, 0, 0, 0);

    // Round-robin among three, two-pixel bursts.
    do_reset();
    prev_busy = 0;
    for (int k = 0; k < 14; k++) begin
      l = (m_granted && m_taken == 1) ? 3'b111 : 3'b000;
      cyc_s(3'b111, l, k, k, k);
      if (busy && !prev_busy) order.push_back(int'(owner));
      prev_busy = busy;
    end
    check("rr_count", order.size() >= 4, 1);
    if (order.size() >= 4) begin
      check("rr_order0", order[0], 0);
      check("rr_order1", order[1], 1);
      check("rr_order2", order[2], 2);
      check("rr_order3", order[3], 0);
    end

    // Burst cap: requester 1 never signals last, requester 2 is waiting.
    do_reset();
    n1 = 0; seen2 = 0;
    for (int k = 0; k < 12; k++) begin
      cyc_s(3'b110, 3'b000, 100 + k, 50, 'h0123);
      if (obs_ack[2]) seen2 = 1;
      if (obs_ack[1] && !seen2) n1++;
    end
    check("cap_acks1", n1, MB);
    check("cap_grant2", seen2, 1);

    // Clipping at the screen edges.
    do_reset();
    cyc_s(3'b001, 3'b000, 320, 5, 'h1111);
    cyc_s(3'b001, 3'b000, 320, 5, 'h1111);
    cyc_s(3'b001, 3'b000, 5, 240, 'h2222);
    cyc_s(3'b001, 3'b001, 319, 239, 'h3333);
    cyc_s(3'b000, 3'b000, 0, 0, 0);
    check("clip_total", clip_count, 2);
    check("clip_edge_x", vga_x, 319);

    // Owner drops req after one pixel.
    do_reset();
    cyc_s(3'b011, 3'b000, 30, 40, 'h0005);
    cyc_s(3'b011, 3'b000, 30, 40, 'h0005);
    cyc_s(3'b010, 3'b000, 31, 40, 'h0006);
    cyc_s(3'b010, 3'b000, 32, 41, 'h0007);
    cyc_s(3'b010, 3'b010, 32, 41, 'h0007);
    cyc_s(3'b000, 3'b000, 0, 0, 0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    cyc_s(3'b111, 3'b000, 60, 70, 'h00aa);
    cyc_s(3'b111, 3'b000, 60, 70, 'h00aa);
    req = 3'b111; last = '0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_ack", ack, 0);
    check("arst_plot", vga_plot, 0);
    check("arst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc_s(3'b111, 3'b000, 61, 70, 'h00bb);
    check("arst_first_owner", owner, 0);
    cyc_s(3'b111, 3'b111, 61, 70, 'h00bb);

    // Randomized traffic.
    do_reset();
    r = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) r = NREQ'($urandom);
      l = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      for (int i = 0; i < NREQ; i++) begin
        x[i*XW +: XW] = XW'(rand_x());
        y[i*YW +: YW] = YW'(rand_y());
        c[i*CW +: CW] = CW'($urandom);
      end
      cyc(r, l, x, y, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
